morse_shift_sequencer: RTL and testbench



---
 rtl/morse_seq_pkg.sv | 25 ++
 rtl/morse_shift_sequencer_rate_divider.sv | 32 +++
 rtl/morse_shift_sequencer.sv | 137 +++++++++++++
 tb/tb_morse_shift_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/morse_seq_pkg.sv
// Shared types and letter table for the Morse shift-register sequencer.
package morse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int SEQ_WIDTH = 12;

  // dot=1, dash=111, one 0 between elements, first element in bit 0
  localparam logic [11:0] PATTERN [0:7] = '{
    12'h01D,  // A .-
    12'h157,  // B -...
    12'h5D7,  // C -.-.
    12'h057,  // D -..
    12'h001,  // E .
    12'h175,  // F ..-.
    12'h177,  // G --.
    12'h055   // H ....
  };

endpackage

// File: rtl/morse_shift_sequencer_rate_divider.sv
// Symbol-rate down-counter: pulses tick at 0 while running, then reloads DIV-1.
module rate_divider #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run & ~clear & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = RELOAD;
    else if (run)
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/morse_shift_sequencer.sv
// Sequences a serial shift register to send one Morse letter A-H.
// Optional MORSE_SEQ_REPEAT_EN: a start held high through DONE reloads the same letter.
module morse_shift_sequencer
  import morse_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DIV   = 25000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_loadn,
  output logic             sr_enable,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH + 1);

  seq_state_e       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [SW-1:0]    shift_cnt_q, shift_cnt_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic             sr_loadn_q, sr_loadn_d;
  logic             sr_enable_q, sr_enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_q;
  logic             start_edge;
  logic             div_clear, div_run, tick;

  assign start_edge = start & ~start_q;

  // Counter is reloaded when LOAD is entered so its first tick lands DIV-1
  // cycles into LOAD; the registered enable then shows DIV cycles after LOAD.
  rate_divider #(.DIV(DIV)) u_rate_divider (
    .clk    (clk),
    .resetn (resetn),
    .clear  (div_clear),
    .run    (div_run),
    .tick   (tick)
  );

  // Outputs are computed for the state being entered, so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shift_cnt_d = shift_cnt_q;
    sr_data_d   = sr_data_q;
    sr_loadn_d  = 1'b1;
    sr_enable_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    div_clear   = 1'b0;
    div_run     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          sel_d       = sel;
          state_d     = LOAD;
          sr_loadn_d  = 1'b0;
          sr_data_d   = WIDTH'(PATTERN[sel]);
          busy_d      = 1'b1;
          div_clear   = 1'b1;
          shift_cnt_d = '0;
        end
      end
      LOAD, SHIFT: begin
        if (abort) begin
          state_d    = IDLE;
          sr_loadn_d = 1'b0;
          sr_data_d  = '0;
          div_clear  = 1'b1;
        end else if (shift_cnt_q == SW'(WIDTH)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          div_run = 1'b1;
          if (tick) begin
            sr_enable_d = 1'b1;
            shift_cnt_d = shift_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MORSE_SEQ_REPEAT_EN
        if (start && !abort) begin
          state_d     = LOAD;
          sr_loadn_d  = 1'b0;
          sr_data_d   = WIDTH'(PATTERN[sel_q]);
          busy_d      = 1'b1;
          div_clear   = 1'b1;
          shift_cnt_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      shift_cnt_q <= '0;
      sr_data_q   <= '0;
      sr_loadn_q  <= 1'b1;
      sr_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shift_cnt_q <= shift_cnt_d;
      sr_data_q   <= sr_data_d;
      sr_loadn_q  <= sr_loadn_d;
      sr_enable_q <= sr_enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_q     <= start;
    end
  end

  assign sr_data   = sr_data_q;
  assign sr_loadn  = sr_loadn_q;
  assign sr_enable = sr_enable_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_morse_shift_sequencer.sv
// Scoreboard bench: two DUTs (DIV=4 and DIV=1), expected output events queued by stimulus.
module tb_morse_shift_sequencer;

  localparam logic [2:0] K_LD = 3'b001, K_EN = 3'b010, K_DN = 3'b100;
  localparam logic [11:0] PAT [0:7] = '{12'h01D, 12'h157, 12'h5D7, 12'h057,
                                        12'h001, 12'h175, 12'h177, 12'h055};

  typedef struct {
    int         d;
    logic [2:0] kind;
    logic [11:0] data;
    logic       busy;
    logic       bitv;
    int         gap;
  } ev_t;

  logic clk = 1'b0, resetn = 1'b0, abort = 1'b0;
  logic [2:0] sel = '0;
  logic [1:0] start = '0;
  logic [1:0][11:0] o_data;
  logic [1:0] o_loadn, o_en, o_busy, o_done;

  ev_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int last_ev [2];
  logic [11:0] sreg [2];

  always #5 clk = ~clk;

  morse_shift_sequencer #(.WIDTH(12), .DIV(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start[0]), .abort(abort), .sel(sel),
    .sr_data(o_data[0]), .sr_loadn(o_loadn[0]), .sr_enable(o_en[0]),
    .busy(o_busy[0]), .done(o_done[0]));

  morse_shift_sequencer #(.WIDTH(12), .DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start[1]), .abort(abort), .sel(sel),
    .sr_data(o_data[1]), .sr_loadn(o_loadn[1]), .sr_enable(o_en[1]),
    .busy(o_busy[1]), .done(o_done[1]));

  // Monitor: every strobe becomes an event, compared against the queue head.
  always @(negedge clk) begin
    ev_t act, exp;
    logic ok;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      act.d    = d;
      act.kind = {o_done[d], o_en[d], ~o_loadn[d]};
      if (act.kind != 3'b000) begin
        act.data = o_data[d];
        act.busy = o_busy[d];
        act.bitv = sreg[d][0];
        act.gap  = cyc - last_ev[d];
        last_ev[d] = cyc;
        if (!o_loadn[d]) sreg[d] = o_data[d];
        else if (o_en[d]) sreg[d] = sreg[d] >> 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event dut%0d cyc %0d: got kind=%b data=%h busy=%b, want none",
                   d, cyc, act.kind, act.data, act.busy);
        end else begin
          exp = exp_q.pop_front();
          ok = (exp.d == d) && (exp.kind == act.kind) && (exp.busy == act.busy) &&
               (exp.gap < 0 || exp.gap == act.gap) &&
               (act.kind != K_LD || exp.data == act.data) &&
               (act.kind != K_EN || exp.bitv == act.bitv);
          if (!ok) begin
            errors++;
            $display("FAIL event dut%0d cyc %0d: got kind=%b data=%h busy=%b bit=%b gap=%0d, want dut%0d kind=%b data=%h busy=%b bit=%b gap=%0d",
                     d, cyc, act.kind, act.data, act.busy, act.bitv, act.gap,
                     exp.d, exp.kind, exp.data, exp.busy, exp.bitv, exp.gap);
          end
        end
      end
    end
  end

  task automatic push(input int d, input logic [2:0] kind, input logic [11:0] data,
                      input logic busy, input logic bitv, input int gap);
    ev_t e;
    e.d = d; e.kind = kind; e.data = data; e.busy = busy; e.bitv = bitv; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_tx(input int d, input logic [11:0] pat, input int div, input int ld_gap);
    push(d, K_LD, pat, 1'b1, 1'b0, ld_gap);
    for (int k = 0; k < 12; k++) push(d, K_EN, 12'h000, 1'b1, pat[k], div);
    push(d, K_DN, 12'h000, 1'b0, 1'b0, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    step(1);
    start[d] = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset(input int d, input string name);
    checks++;
    if (o_data[d] !== 12'h000 || o_loadn[d] !== 1'b1 || o_en[d] !== 1'b0 ||
        o_busy[d] !== 1'b0 || o_done[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s dut%0d: got data=%h loadn=%b en=%b busy=%b done=%b, want 000 1 0 0 0",
               name, d, o_data[d], o_loadn[d], o_en[d], o_busy[d], o_done[d]);
    end
  endtask

  initial begin
    last_ev[0] = 0; last_ev[1] = 0;
    sreg[0] = '0;   sreg[1] = '0;
    step(2);
    check_reset(0, "reset_state");
    check_reset(1, "reset_state");
    resetn = 1'b1;
    step(2);

    // Letter A
    sel = 3'd0;
    push_tx(0, PAT[0], 4, -1);
    pulse_start(0);
    step(60);
    check_drained("letter_a");

    // Letter B, with a retrigger and sel change mid-shift that must be ignored
    sel = 3'd1;
    push_tx(0, PAT[1], 4, -1);
    pulse_start(0);
    step(10);
    sel = 3'd4;
    pulse_start(0);
    step(60);
    check_drained("letter_b_retrigger");

    // Abort on the cycle that would give the 5th enable
    sel = 3'd2;
    push(0, K_LD, PAT[2], 1'b1, 1'b0, -1);
    for (int k = 0; k < 4; k++) push(0, K_EN, 12'h000, 1'b1, PAT[2][k], 4);
    push(0, K_LD, 12'h000, 1'b0, 1'b0, 4);
    pulse_start(0);
    step(19);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(30);
    check_drained("abort");

    // Abort while idle does nothing
    abort = 1'b1;
    step(3);
    abort = 1'b0;
    step(3);

    // Asynchronous reset mid-SHIFT
    sel = 3'd3;
    push(0, K_LD, PAT[3], 1'b1, 1'b0, -1);
    for (int k = 0; k < 2; k++) push(0, K_EN, 12'h000, 1'b1, PAT[3][k], 4);
    pulse_start(0);
    step(10);
    resetn = 1'b0;
    #1;
    check_reset(0, "async_reset");
    step(2);
    resetn = 1'b1;
    step(20);
    check_drained("async_reset");

    // DIV=1, letter E, start held high across DONE
    sel = 3'd4;
    push_tx(1, PAT[4], 1, -1);
`ifdef MORSE_SEQ_REPEAT_EN
    push_tx(1, PAT[4], 1, 1);
`endif
    start[1] = 1'b1;
    step(20);
    start[1] = 1'b0;
    step(40);
    check_drained("div1_hold_start");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
